op_integrator: RTL and testbench

- Third-order cascaded integrator, triggered once per audio sample by the lr_clk frame strobe.
- Exact inverse of the per-channel third-order differentiator. Wrap-around integrator∘differentiator is identity for matching widths.
- Sits after the differentiator/beamformer sum path to restore the pre-emphasised signal, or acts as the integrator half of a CIC decimator.
- Three accumulations run sequentially over three clk cycles per sample.

---
 rtl/op_integrator.sv | 129 ++++++++++++
 tb/tb_op_integrator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/op_integrator.sv
// op_integrator: third-order cascaded integrator, one sample per lr_clk frame.
// The three accumulations run sequentially on clk, so a new sample can be
// accepted no faster than every 4 clk cycles. This block undoes a
// third-order differentiator exactly (modular wrap on both sides).
module op_integrator #(
  parameter int IN_W        = 19,
  parameter int ACC_W       = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lr_clk,
  input  logic                    clr,
  input  logic signed [IN_W-1:0]  in,
  output logic signed [ACC_W-1:0] out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I1   = 2'd1,
    I2   = 2'd2,
    I3   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    hist_reg;
  logic                    lr_edge;

  logic signed [IN_W-1:0]  in_q_reg;
  logic signed [ACC_W-1:0] acc1_reg, acc2_reg, acc3_reg;
  logic signed [ACC_W-1:0] out_reg;
  logic                    out_valid_reg;
  logic                    overrun_reg;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum3;

  // Bring lr_clk into the clk domain and remember the previous synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], lr_clk};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Single-cycle pulse on each rising edge of the synchronised frame strobe.
  assign lr_edge = sync_reg[SYNC_STAGES-1] & ~hist_reg;

  // The captured sample is widened with its sign so the wrap is consistent.
  assign in_ext = ACC_W'(in_q_reg);
  assign sum3   = acc3_reg + acc2_reg;

  // State register for the integration sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: an edge in IDLE starts a sequence; clr always wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (lr_edge) state_next = I1;
      I1:      state_next = I2;
      I2:      state_next = I3;
      I3:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next = IDLE;
    end
  end

  // Datapath: one accumulation per state, result published from I3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q_reg      <= '0;
      acc1_reg      <= '0;
      acc2_reg      <= '0;
      acc3_reg      <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (clr) begin
        // out deliberately keeps its last value across a clear
        in_q_reg    <= '0;
        acc1_reg    <= '0;
        acc2_reg    <= '0;
        acc3_reg    <= '0;
        overrun_reg <= 1'b0;
      end else begin
        // an edge arriving mid-sequence is lost; flag it and carry on
        if (lr_edge && (state_reg != IDLE)) begin
          overrun_reg <= 1'b1;
        end
        case (state_reg)
          IDLE: if (lr_edge) in_q_reg <= in;
          I1:   acc1_reg <= acc1_reg + in_ext;
          I2:   acc2_reg <= acc2_reg + acc1_reg;
          I3: begin
            acc3_reg      <= sum3;
            out_reg       <= sum3;
            out_valid_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_op_integrator.sv
// Directed bench for op_integrator: impulse, step, wrap, inverse, overrun,
// clear and reset aborts.
module tb_op_integrator;

  localparam int IN_W  = 19;
  localparam int ACC_W = 19;

  logic                    clk;
  logic                    rst;
  logic                    lr_clk;
  logic                    clr;
  logic signed [IN_W-1:0]  in;
  logic signed [ACC_W-1:0] out;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;

  int n_cmp = 0;
  int n_mis = 0;

  op_integrator #(.IN_W(IN_W), .ACC_W(ACC_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .lr_clk    (lr_clk),
    .clr       (clr),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Present one sample on an lr_clk rising edge, wait (bounded) for the
  // result, check value, latency from the pin and single-cycle pulse width.
  task automatic send(input logic signed [IN_W-1:0] v,
                      input logic signed [31:0] expv, input string tag);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    @(negedge clk);
    in     = v;
    lr_clk = 1'b1;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk(tag, out, expv);
      chk({tag, "_latency"}, cnt, 6);
      @(negedge clk);
      chk({tag, "_pulse"}, out_valid, 0);
    end
    $display("sample %s in=%0d out=%0d expected=%0d", tag, v, out, expv);
    lr_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int xs [8];
    int x1, x2, x3, d;
    int vcnt;
    logic [31:0] dw;
    logic signed [ACC_W-1:0] last_out;

    rst    = 1'b1;
    lr_clk = 1'b0;
    clr    = 1'b0;
    in     = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // impulse
    send(19'sd1, 1, "imp0");
    send(19'sd0, 3, "imp1");
    send(19'sd0, 6, "imp2");
    send(19'sd0, 10, "imp3");
    chk("imp_overrun", overrun, 0);

    // step
    do_clr();
    send(19'sd1, 1, "step0");
    send(19'sd1, 4, "step1");
    send(19'sd1, 10, "step2");
    send(19'sd1, 20, "step3");
    send(19'sd1, 35, "step4");

    // wrap at the positive limit
    do_clr();
    send(19'sd262143, 262143, "wrap0");
    send(19'sd262143, -4, "wrap1");

    // inverse: third-order difference then integrate gives the original back
    do_clr();
    xs = '{100, -200, 262143, -262144, 5, 0, 12345, -1};
    x1 = 0; x2 = 0; x3 = 0;
    for (int i = 0; i < 8; i++) begin
      d  = xs[i] - 3 * x1 + 3 * x2 - x3;
      dw = d;
      send(dw[IN_W-1:0], xs[i], $sformatf("inv%0d", i));
      x3 = x2; x2 = x1; x1 = xs[i];
    end

    // overrun: two edge pulses 2 clk apart
    do_clr();
    @(negedge clk);
    in     = 19'sd7;
    lr_clk = 1'b1;
    @(negedge clk);
    lr_clk = 1'b0;
    @(negedge clk);
    lr_clk = 1'b1;
    vcnt = 0;
    last_out = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid) begin
        vcnt++;
        last_out = out;
      end
    end
    lr_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_count", vcnt, 1);
    chk("ovr_out", last_out, 7);
    chk("ovr_flag", overrun, 1);
    $display("overrun valids=%0d out=%0d overrun=%0d", vcnt, last_out, overrun);
    do_clr();
    chk("ovr_clr", overrun, 0);
    send(19'sd5, 5, "after_clr");

    // clr while in I1 aborts the sample and keeps out
    @(negedge clk);
    in     = 19'sd9;
    lr_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("clr_busy_i1", busy, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy_after", busy, 0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("clr_abort_valid", vcnt, 0);
    chk("clr_out_kept", out, 5);
    $display("clr abort valids=%0d out=%0d", vcnt, out);
    lr_clk = 1'b0;
    repeat (4) @(negedge clk);
    send(19'sd2, 2, "post_clr");

    // reset while in I2
    @(negedge clk);
    in     = 19'sd3;
    lr_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    lr_clk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("rst_mid_novalid", vcnt, 0);
    $display("reset abort valids=%0d out=%0d busy=%0d", vcnt, out, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
